point_swapback_pipe: RTL and testbench
======================================

// Module: point_swapback_pipe
// PURPOSE
//  Pipelined, parametrised octant back-transform for the rasterizer line path.
//  - Takes normalised Bresenham offsets (u = major, v = minor, both >= 0) from the line generator.
//  - Maps them to absolute screen coordinates using the per-line octant and origin,
//    with swap, mirror, offset and clip flagging.
//  - Sits between the line generator and the framebuffer write stage; valid/ready on both sides.
//  - Clear mode passes sweep coordinates through untouched.
// PARAMETERS
//  XW     10   screen x coordinate width
//  YW     9    screen y coordinate width
//  OW     10   offset width of in_u/in_v (>= max(XW,YW))
//  X_MAX  640  x >= X_MAX is off-screen
//  Y_MAX  480  y >= Y_MAX is off-screen
//  CNTW   11   width of pt_count
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous reset, active high
//  cfg_valid  in   1     per-line config offered
//  cfg_ready  out  1     config accepted; high only in IDLE
//  cfg_octant in   3     line octant, see table below
//  cfg_clr    in   1     clear-screen mode for this line
//  cfg_x0     in   XW    line origin x
//  cfg_y0     in   YW    line origin y
//  in_valid   in   1     generator point valid
//  in_ready   out  1     point accepted
//  in_u       in   OW    major-axis offset
//  in_v       in   OW    minor-axis offset
//  in_last    in   1     final point of the line
//  out_valid  out  1     screen point valid
//  out_ready  in   1     downstream accepts
//  out_x      out  XW    screen x
//  out_y      out  YW    screen y
//  out_clip   out  1     point lies off-screen; downstream must not write it
//  out_last   out  1     final point of the line
//  line_done  out  1     one-cycle pulse: line fully drained
//  pt_count   out  CNTW  points emitted for the current or last line, saturating
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset
//  - All output registers clear to 0. State goes to IDLE, pipeline is emptied.
//  - After reset: cfg_ready = 1, in_ready = 0.
//  - Reset mid-line discards in-flight points and raises no line_done.
//  FSM IDLE -> ACTIVE -> DRAIN -> IDLE
//  - IDLE: cfg handshake latches octant, clr, x0, y0, clears pt_count, goes to ACTIVE.
//  - ACTIVE: in_ready = ~s2_valid | out_ready.
//    Handshake with in_last = 1 goes to DRAIN; in_ready = 0 from the next cycle on.
//  - DRAIN: leaves when the out_last beat handshakes, returning to IDLE the next cycle.
//    line_done pulses that same cycle; pt_count already includes the last point.
//  - In IDLE and DRAIN, in_valid is ignored (in_ready = 0).
//  Pipeline: 2 register stages, 2-cycle latency when not stalled
//  - S1 swap: steep octant gives (a, b) = (v, u); otherwise (a, b) = (u, v).
//  - S2 mirror/offset: x = x0 +/- a, y = y0 +/- b.
//    Computed signed, XW+2 and YW+2 bits wide, operands zero-extended.
//  - out_clip = (x < 0) | (x >= X_MAX) | (y < 0) | (y >= Y_MAX).
//  - out_x and out_y are the low XW / YW bits of the result.
//  - Stall: each stage holds its data while its downstream is valid and not ready.
//    No bubbles are inserted and no beat is lost or duplicated.
//    out_* stay stable while out_valid & ~out_ready.
//  Octant table (steep, x sign, y sign)
//  - 0: steep +x +y     - 1: shallow +x +y
//  - 2: shallow -x +y   - 3: steep -x +y
//  - 4: steep -x -y     - 5: shallow -x -y
//  - 6: shallow +x -y   - 7: steep +x -y
//  Clear mode (cfg_clr = 1)
//  - No swap and no offset.
//  - out_x = in_u[XW-1:0], out_y = in_v[YW-1:0], out_clip = 0.
//  - Latency and handshake are identical to normal mode.
//  pt_count
//  - Increments on each out handshake.
//  - Saturates at all-ones.
//  - Holds after line_done until the next cfg accept.
// TESTING
//  - Oct1, origin (100,50), points (0,0), (1,0), (2,1) last, out_ready = 1
//    -> (100,50), (101,50), (102,51) at cycles +2 after each input.
//    line_done pulses once, pt_count = 3.
//  - Oct4, origin (10,10), point u=3, v=12 -> x = 10-12 = -2, y = 10-3 = 7: out_clip = 1, out_x = 10'h3FE.
//  - Oct0, origin (639,479), point u=1, v=0 -> (639,480): out_clip = 1.
//    Oct7 origin (0,5), u=5, v=0 -> (0,0): clip = 0.
//  - Random out_ready (50%), 200-point line: output sequence equals the input sequence exactly.
//    Outputs stay stable under stall; pt_count = 200.
//  - Clear mode, origin (300,300), oct 3, point (639,479) -> (639,479), clip = 0.
//  - rst during ACTIVE with 2 points in flight -> out_valid = 0 next cycle, no line_done, cfg_ready = 1.
//    cfg_valid during ACTIVE is not accepted.

Source files
------------

// File: rtl/point_swapback_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : point_swapback_pipe_if
// Description : Bundles the three handshake channels of point_swapback_pipe.
//               - cfg : per-line config (octant, clear mode, origin x0/y0).
//               - in  : normalised Bresenham offsets (u major, v minor) from
//                       the line generator.
//               - out : absolute screen point to the framebuffer write stage.
//               The master modport is the side that drives configs and
//               points and consumes screen points. The slave modport is the
//               back-transform pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface point_swapback_pipe_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int OW = 10
);
  // config channel
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_octant;
  logic          cfg_clr;
  logic [XW-1:0] cfg_x0;
  logic [YW-1:0] cfg_y0;
  // point input channel
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_u;
  logic [OW-1:0] in_v;
  logic          in_last;
  // screen point output channel
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_clip;
  logic          out_last;

  modport master (
    output cfg_valid, cfg_octant, cfg_clr, cfg_x0, cfg_y0,
    input  cfg_ready,
    output in_valid, in_u, in_v, in_last,
    input  in_ready,
    input  out_valid, out_x, out_y, out_clip, out_last,
    output out_ready
  );

  modport slave (
    input  cfg_valid, cfg_octant, cfg_clr, cfg_x0, cfg_y0,
    output cfg_ready,
    input  in_valid, in_u, in_v, in_last,
    output in_ready,
    output out_valid, out_x, out_y, out_clip, out_last,
    input  out_ready
  );
endinterface
`default_nettype wire

// File: rtl/point_swapback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : point_swapback_pipe
// Description : Pipelined octant back-transform for the rasterizer line path.
//               It maps normalised Bresenham offsets (u, v >= 0) to absolute
//               screen coordinates using the per-line octant and origin. It
//               applies swap, mirror and offset, and flags off-screen points
//               for clipping. In clear mode the sweep coordinates pass
//               through untouched. The pipe has 2 register stages with
//               valid/ready flow control on every channel.
// Ports       : clk       - clock
//               rst       - synchronous reset, active high
//               bus       - slave view of cfg / in / out channels
//               line_done - one-cycle pulse after the last beat of a line
//               pt_count  - points emitted for current/last line (saturating)
//               busy      - high whenever a line is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module point_swapback_pipe #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int OW    = 10,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480,
  parameter int CNTW  = 11
) (
  input  wire logic              clk,
  input  wire logic              rst,
  point_swapback_pipe_if.slave   bus,
  output logic                   line_done,
  output logic [CNTW-1:0]        pt_count,
  output logic                   busy
);

  // The signed x/y results carry two spare bits. That is enough for an
  // origin plus or minus a full offset without wrapping.
  localparam int XE = XW + 2;
  localparam int YE = YW + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic            line_done_q;
  logic [CNTW-1:0] pt_count_q;

  // Per-line configuration. It is held constant from cfg accept until the
  // line drains, so both stages can read it directly.
  logic [2:0]      oct_q;
  logic            clr_q;
  logic [XW-1:0]   x0_q;
  logic [YW-1:0]   y0_q;

  // Stage 1: swapped operands
  logic            s1_valid_q;
  logic [OW-1:0]   s1_a_q;
  logic [OW-1:0]   s1_b_q;
  logic            s1_last_q;

  // Stage 2: output registers
  logic            s2_valid_q;
  logic [XW-1:0]   out_x_q;
  logic [YW-1:0]   out_y_q;
  logic            out_clip_q;
  logic            out_last_q;

  // --------------------------------------------------------------------------
  // Octant decode: the steep octants swap major/minor, and the sign bits
  // choose mirroring.
  // --------------------------------------------------------------------------
  logic steep;
  logic x_neg;
  logic y_neg;

  always_comb begin
    steep = 1'b0;
    x_neg = 1'b0;
    y_neg = 1'b0;
    case (oct_q)
      3'd0: begin steep = 1'b1; x_neg = 1'b0; y_neg = 1'b0; end
      3'd1: begin steep = 1'b0; x_neg = 1'b0; y_neg = 1'b0; end
      3'd2: begin steep = 1'b0; x_neg = 1'b1; y_neg = 1'b0; end
      3'd3: begin steep = 1'b1; x_neg = 1'b1; y_neg = 1'b0; end
      3'd4: begin steep = 1'b1; x_neg = 1'b1; y_neg = 1'b1; end
      3'd5: begin steep = 1'b0; x_neg = 1'b1; y_neg = 1'b1; end
      3'd6: begin steep = 1'b0; x_neg = 1'b0; y_neg = 1'b1; end
      default: begin steep = 1'b1; x_neg = 1'b0; y_neg = 1'b1; end
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic s2_adv;     // stage 2 can take a new beat (and so can stage 1)
  logic in_rdy;
  logic in_fire;
  logic out_fire;
  logic cfg_rdy;

  // Stage 1 always advances whenever stage 2 advances. Tying input
  // acceptance to the stage-2 advance condition means stage 1 never has to
  // hold one beat while taking another.
  assign s2_adv   = ~s2_valid_q | bus.out_ready;
  assign in_rdy   = (state_q == S_ACTIVE) & s2_adv;
  assign in_fire  = bus.in_valid & in_rdy;
  assign out_fire = s2_valid_q & bus.out_ready;
  assign cfg_rdy  = (state_q == S_IDLE);

  // --------------------------------------------------------------------------
  // Stage 1: swap (steep octants exchange major and minor; clear mode never
  // swaps)
  // --------------------------------------------------------------------------
  logic swap;
  assign swap = steep & ~clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_last_q  <= 1'b0;
    end else if (s2_adv) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_a_q    <= swap ? bus.in_v : bus.in_u;
        s1_b_q    <= swap ? bus.in_u : bus.in_v;
        s1_last_q <= bus.in_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: mirror, offset and clip
  // --------------------------------------------------------------------------
  logic [XE-1:0] x0_ext;
  logic [XE-1:0] a_ext;
  logic [XE-1:0] x_d;
  logic [YE-1:0] y0_ext;
  logic [YE-1:0] b_ext;
  logic [YE-1:0] y_d;
  logic          clip_d;
  logic [XW-1:0] out_x_d;
  logic [YW-1:0] out_y_d;

  always_comb begin
    x0_ext = XE'(x0_q);
    a_ext  = XE'(s1_a_q);
    y0_ext = YE'(y0_q);
    b_ext  = YE'(s1_b_q);
    x_d    = x_neg ? (x0_ext - a_ext) : (x0_ext + a_ext);
    y_d    = y_neg ? (y0_ext - b_ext) : (y0_ext + b_ext);
    // A negative result shows up as a set sign bit. A positive overflow is
    // caught by the unsigned compare against the screen limit.
    clip_d = x_d[XE-1] | (x_d >= XE'(X_MAX)) |
             y_d[YE-1] | (y_d >= YE'(Y_MAX));
    out_x_d = x_d[XW-1:0];
    out_y_d = y_d[YW-1:0];
    if (clr_q) begin
      out_x_d = s1_a_q[XW-1:0];
      out_y_d = s1_b_q[YW-1:0];
      clip_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_clip_q <= 1'b0;
      out_last_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_x_q    <= out_x_d;
        out_y_q    <= out_y_d;
        out_clip_q <= clip_d;
        out_last_q <= s1_last_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line control FSM: IDLE -> ACTIVE -> DRAIN -> IDLE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_done_q <= 1'b0;
      pt_count_q  <= '0;
      oct_q       <= '0;
      clr_q       <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
    end else begin
      line_done_q <= 1'b0;
      if (out_fire && !(&pt_count_q)) begin
        pt_count_q <= pt_count_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            oct_q      <= bus.cfg_octant;
            clr_q      <= bus.cfg_clr;
            x0_q       <= bus.cfg_x0;
            y0_q       <= bus.cfg_y0;
            pt_count_q <= '0;
            state_q    <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (in_fire && bus.in_last) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The count increment above lands on this same edge, so pt_count
          // already includes the final point when line_done is seen.
          if (out_fire && out_last_q) begin
            line_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cfg_ready = cfg_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_clip  = out_clip_q;
  assign bus.out_last  = out_last_q;
  assign line_done     = line_done_q;
  assign pt_count      = pt_count_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_point_swapback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_point_swapback_pipe
// Description : Directed self-checking bench for point_swapback_pipe. It
//               covers reset state, streaming latency, octant mirroring,
//               clipping boundaries, a randomly back-pressured 200-point
//               line, clear mode, and reset in the middle of a line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_point_swapback_pipe;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int OW   = 10;
  localparam int CNTW = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            line_done;
  logic [CNTW-1:0] pt_count;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  point_swapback_pipe_if #(.XW(XW), .YW(YW), .OW(OW)) bus ();

  point_swapback_pipe #(
    .XW(XW), .YW(YW), .OW(OW), .X_MAX(640), .Y_MAX(480), .CNTW(CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .line_done(line_done),
    .pt_count (pt_count),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [2:0] oct, input logic clr,
                            input logic [XW-1:0] x0, input logic [YW-1:0] y0);
    bus.cfg_valid  = 1'b1;
    bus.cfg_octant = oct;
    bus.cfg_clr    = clr;
    bus.cfg_x0     = x0;
    bus.cfg_y0     = y0;
    tick();
    bus.cfg_valid  = 1'b0;
  endtask

  // Run a one-point line with out_ready held high and check the result.
  task automatic one_point(input string pfx, input logic [2:0] oct, input logic clr,
                           input logic [XW-1:0] x0, input logic [YW-1:0] y0,
                           input logic [OW-1:0] u, input logic [OW-1:0] v,
                           input logic [XW-1:0] ex, input logic [YW-1:0] ey,
                           input logic eclip);
    bus.out_ready = 1'b1;
    start_line(oct, clr, x0, y0);
    bus.in_valid = 1'b1;
    bus.in_u     = u;
    bus.in_v     = v;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check({pfx, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({pfx, "_x"},     32'(bus.out_x),     32'(ex));
    check({pfx, "_y"},     32'(bus.out_y),     32'(ey));
    check({pfx, "_clip"},  32'(bus.out_clip),  32'(eclip));
    check({pfx, "_last"},  32'(bus.out_last),  32'd1);
    tick();
    check({pfx, "_done"},  32'(line_done),     32'd1);
    check({pfx, "_count"}, 32'(pt_count),      32'd1);
  endtask

  initial begin
    int            in_idx;
    int            out_idx;
    int            cyc;
    logic          prev_stall;
    logic [20:0]   saved;
    logic          in_fire;
    logic          out_fire;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;

    rst            = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_octant = '0;
    bus.cfg_clr    = 1'b0;
    bus.cfg_x0     = '0;
    bus.cfg_y0     = '0;
    bus.in_valid   = 1'b0;
    bus.in_u       = '0;
    bus.in_v       = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ---------------- reset state
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_count",     32'(pt_count),      32'd0);
    check("rst_done",      32'(line_done),     32'd0);

    // ---------------- octant 1 streaming line, origin (100,50)
    bus.out_ready = 1'b1;
    start_line(3'd1, 1'b0, 10'd100, 9'd50);
    check("t1_busy",      32'(busy),          32'd1);
    check("t1_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("t1_in_ready",  32'(bus.in_ready),  32'd1);
    bus.in_valid = 1'b1; bus.in_u = 10'd0; bus.in_v = 10'd0; bus.in_last = 1'b0;
    tick();
    bus.in_u = 10'd1; bus.in_v = 10'd0;
    tick();
    check("t1_p0", 32'({bus.out_valid, bus.out_x, bus.out_y, bus.out_clip, bus.out_last}),
          32'({1'b1, 10'd100, 9'd50, 1'b0, 1'b0}));
    bus.in_u = 10'd2; bus.in_v = 10'd1; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("t1_p1", 32'({bus.out_valid, bus.out_x, bus.out_y, bus.out_clip, bus.out_last}),
          32'({1'b1, 10'd101, 9'd50, 1'b0, 1'b0}));
    check("t1_drain_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("t1_p2", 32'({bus.out_valid, bus.out_x, bus.out_y, bus.out_clip, bus.out_last}),
          32'({1'b1, 10'd102, 9'd51, 1'b0, 1'b1}));
    check("t1_done_early", 32'(line_done), 32'd0);
    tick();
    check("t1_done",      32'(line_done),     32'd1);
    check("t1_count",     32'(pt_count),      32'd3);
    check("t1_out_empty", 32'(bus.out_valid), 32'd0);
    check("t1_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    check("t1_done_pulse", 32'(line_done), 32'd0);
    check("t1_count_hold", 32'(pt_count),  32'd3);

    // ---------------- mirroring and clip boundaries
    one_point("oct4_neg_x", 3'd4, 1'b0, 10'd10,  9'd10,  10'd3, 10'd12, 10'h3FE, 9'd7,   1'b1);
    one_point("oct0_y480",  3'd0, 1'b0, 10'd639, 9'd479, 10'd1, 10'd0,  10'd639, 9'd480, 1'b1);
    one_point("oct7_zero",  3'd7, 1'b0, 10'd0,   9'd5,   10'd5, 10'd0,  10'd0,   9'd0,   1'b0);
    one_point("oct2_x_m1",  3'd2, 1'b0, 10'd0,   9'd5,   10'd1, 10'd0,  10'h3FF, 9'd5,   1'b1);
    one_point("oct1_x639",  3'd1, 1'b0, 10'd600, 9'd5,   10'd39, 10'd2, 10'd639, 9'd7,   1'b0);

    // ---------------- clear mode: no swap, no offset, no clip
    one_point("clr_oct3",   3'd3, 1'b1, 10'd300, 9'd300, 10'd639, 10'd479, 10'd639, 9'd479, 1'b0);

    // ---------------- 200-point line, octant 6, origin (100,400), random out_ready
    // Point i = (u=i, v=i/2) -> x = 100+i, y = 400-i/2.
    start_line(3'd6, 1'b0, 10'd100, 9'd400);
    in_idx     = 0;
    out_idx    = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    saved      = '0;
    bus.in_valid = 1'b1; bus.in_u = 10'd0; bus.in_v = 10'd0; bus.in_last = 1'b0;
    while (out_idx < 200 && cyc < 4000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("rnd_stall_hold",
              32'({bus.out_valid, bus.out_x, bus.out_y, bus.out_last}),
              32'({1'b1, saved[19:0]}));
      end
      in_fire  = bus.in_valid & bus.in_ready;
      out_fire = bus.out_valid & bus.out_ready;
      if (out_fire) begin
        ex = 10'(100 + out_idx);
        ey = 9'(400 - out_idx / 2);
        check("rnd_beat", 32'({bus.out_x, bus.out_y, bus.out_clip, bus.out_last}),
              32'({ex, ey, 1'b0, (out_idx == 199)}));
        out_idx++;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      saved      = {1'b1, bus.out_x, bus.out_y, bus.out_last};
      tick();
      cyc++;
      if (in_fire) begin
        in_idx++;
        if (in_idx < 200) begin
          bus.in_u    = 10'(in_idx);
          bus.in_v    = 10'(in_idx / 2);
          bus.in_last = (in_idx == 199);
        end else begin
          bus.in_valid = 1'b0;
          bus.in_last  = 1'b0;
        end
      end
    end
    check("rnd_beats_out", 32'(out_idx),   32'd200);
    check("rnd_done",      32'(line_done), 32'd1);
    check("rnd_count",     32'(pt_count),  32'd200);
    tick();
    check("rnd_no_extra",  32'(bus.out_valid), 32'd0);

    // ---------------- reset mid-line with 2 points in flight
    bus.out_ready = 1'b0;
    start_line(3'd1, 1'b0, 10'd5, 9'd5);
    bus.in_valid = 1'b1; bus.in_u = 10'd1; bus.in_v = 10'd1; bus.in_last = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_octant = 3'd5;
    tick();
    check("mid_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("mid_busy",      32'(busy),          32'd1);
    bus.in_u = 10'd2; bus.in_v = 10'd2;
    tick();
    check("mid_in_flight", 32'({bus.out_valid, bus.out_x, bus.out_y}),
          32'({1'b1, 10'd6, 9'd6}));
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_done",      32'(line_done),     32'd0);
    check("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("mid_rst_busy",      32'(busy),          32'd0);
    check("mid_rst_count",     32'(pt_count),      32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("mid_post_done",  32'(line_done),     32'd0);
    check("mid_post_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
